mux2_1_arbiter: RTL and testbench

//   Upstream select generator for mux2_1. Arbitrates between two requesters
//   ("one" and "zero") with round-robin fairness and bounded bursts.

---
 rtl/mux2_1_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mux2_1_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux2_1_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_1_arbiter
//
// Generates the select line for a downstream mux2_1. It arbitrates between
// two requesters, "one" and "zero", using round-robin fairness and a bounded
// burst length. It also qualifies the mux output with a valid/ready handshake.
//
// Parameters
//   MAX_BURST  maximum accepted beats per grant before a forced release (>=1)
//   CNT_W      burst counter width; 2**CNT_W must exceed MAX_BURST
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   req_one    in   requester "one" has data on mux2_1.one
//   last_one   in   current beat from "one" ends its transfer
//   req_zero   in   requester "zero" has data on mux2_1.zero
//   last_zero  in   current beat from "zero" ends its transfer
//   out_ready  in   downstream accepts the mux output this cycle
//   select     out  mux2_1 select (1 = pass "one", 0 = pass "zero"), registered
//   grant_one  out  "one" owns the mux, registered
//   grant_zero out  "zero" owns the mux, registered
//   out_valid  out  mux output carries a valid beat (combinational)
// ---------------------------------------------------------------------------
module mux2_1_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_one,
  input  logic last_one,
  input  logic req_zero,
  input  logic last_zero,
  input  logic out_ready,
  output logic select,
  output logic grant_one,
  output logic grant_zero,
  output logic out_valid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_ONE  = 2'd1,
    GNT_ZERO = 2'd2
  } state_t;

  // A beat taken while the count sits here is the MAX_BURST-th beat of the
  // grant. The count therefore never reaches MAX_BURST and cannot wrap.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic             ptr_one_q, ptr_one_d;   // 1: "one" wins the next tie
  logic [CNT_W-1:0] count_q, count_d;
  logic             select_q, select_d;
  logic             grant_one_q, grant_one_d;
  logic             grant_zero_q, grant_zero_d;

  logic beat_one;
  logic beat_zero;
  logic release_one;
  logic release_zero;

  // The handshake is qualified by the live request. A requester that drops
  // its request mid-grant therefore produces no valid and no beat in that
  // cycle.
  assign beat_one  = (state_q == GNT_ONE)  & req_one  & out_ready;
  assign beat_zero = (state_q == GNT_ZERO) & req_zero & out_ready;

  // A release is either an abandon (request low), a beat marked last,
  // or a beat that exhausts the burst budget.
  assign release_one  = (state_q == GNT_ONE) &
                        (~req_one  | (beat_one  & (last_one  | (count_q == LAST_CNT))));
  assign release_zero = (state_q == GNT_ZERO) &
                        (~req_zero | (beat_zero & (last_zero | (count_q == LAST_CNT))));

  always_comb begin
    state_d   = state_q;
    ptr_one_d = ptr_one_q;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (req_one && (!req_zero || ptr_one_q)) begin
          state_d = GNT_ONE;
        end else if (req_zero) begin
          state_d = GNT_ZERO;
        end
      end

      GNT_ONE: begin
        if (release_one) begin
          count_d   = '0;
          ptr_one_d = 1'b0;
          // Handing over directly on the release edge avoids an IDLE bubble.
          if (req_zero) begin
            state_d = GNT_ZERO;
          end else if (req_one) begin
            state_d = GNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else if (beat_one) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      GNT_ZERO: begin
        if (release_zero) begin
          count_d   = '0;
          ptr_one_d = 1'b1;
          if (req_one) begin
            state_d = GNT_ONE;
          end else if (req_zero) begin
            state_d = GNT_ZERO;
          end else begin
            state_d = IDLE;
          end
        end else if (beat_zero) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state so that they change on the
  // same edge as the state. Select holds its last value through IDLE, so the
  // mux never sees a spurious toggle.
  always_comb begin
    grant_one_d  = (state_d == GNT_ONE);
    grant_zero_d = (state_d == GNT_ZERO);
    case (state_d)
      GNT_ONE:  select_d = 1'b1;
      GNT_ZERO: select_d = 1'b0;
      default:  select_d = select_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_one_q    <= 1'b1;
      count_q      <= '0;
      select_q     <= 1'b0;
      grant_one_q  <= 1'b0;
      grant_zero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_one_q    <= ptr_one_d;
      count_q      <= count_d;
      select_q     <= select_d;
      grant_one_q  <= grant_one_d;
      grant_zero_q <= grant_zero_d;
    end
  end

  assign select     = select_q;
  assign grant_one  = grant_one_q;
  assign grant_zero = grant_zero_q;
  // State resets asynchronously, so out_valid drops as soon as rst rises.
  assign out_valid  = ((state_q == GNT_ONE)  & req_one) |
                      ((state_q == GNT_ZERO) & req_zero);

endmodule

// File: tb/tb_mux2_1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_1_arbiter
//
// Directed, table-driven bench for mux2_1_arbiter with MAX_BURST=8.
//
// Each table row describes one clock cycle. Inputs are driven at the falling
// edge. Outputs are sampled 1 ns later, so each row shows the state that was
// reached at the previous rising edge, plus out_valid computed from the
// current inputs. A row can request a reset pulse before it is applied.
// A hand-written sequence at the end covers the asynchronous mid-burst reset.
// ---------------------------------------------------------------------------
module tb_mux2_1_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_one = 1'b0;
  logic last_one = 1'b0;
  logic req_zero = 1'b0;
  logic last_zero = 1'b0;
  logic out_ready = 1'b0;
  logic select;
  logic grant_one;
  logic grant_zero;
  logic out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux2_1_arbiter #(.MAX_BURST(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_one    (req_one),
    .last_one   (last_one),
    .req_zero   (req_zero),
    .last_zero  (last_zero),
    .out_ready  (out_ready),
    .select     (select),
    .grant_one  (grant_one),
    .grant_zero (grant_zero),
    .out_valid  (out_valid)
  );

  typedef struct {
    bit    rb;                       // pulse reset before this row
    bit    r1, l1, r0, l0, rdy;      // stimulus
    bit    g1, g0, sel, val;         // expected outputs
    string tag;
  } vec_t;

  vec_t vecs[$];

  // Appends n identical rows to the table.
  function automatic void add(input bit rb, input bit r1, input bit l1,
                              input bit r0, input bit l0, input bit rdy,
                              input bit g1, input bit g0, input bit sel,
                              input bit val, input string tag, input int n = 1);
    vec_t v;
    v.rb = rb; v.r1 = r1; v.l1 = l1; v.r0 = r0; v.l0 = l0; v.rdy = rdy;
    v.g1 = g1; v.g0 = g0; v.sel = sel; v.val = val; v.tag = tag;
    for (int k = 0; k < n; k++) begin
      vecs.push_back(v);
      v.rb = 1'b0;
    end
  endfunction

  task automatic check_bit(input string name, input logic act, input bit exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input bit g1, input bit g0,
                               input bit sel, input bit val);
    check_bit({name, ".grant_one"},  grant_one,  g1);
    check_bit({name, ".grant_zero"}, grant_zero, g0);
    check_bit({name, ".select"},     select,     sel);
    check_bit({name, ".out_valid"},  out_valid,  val);
    tests_run++;
    if (grant_one === 1'b1 && grant_zero === 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s.onehot: got both grants 1, expected at most one", name);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //   rb r1 l1 r0 l0 rdy   g1 g0 sel val
    // 1: single requester "one", last on beat 3, then drop -> IDLE
    add(1, 0,0,0,0,1,  0,0,0,0, "t1_reset");
    add(0, 1,0,0,0,1,  0,0,0,0, "t1_req");
    add(0, 1,0,0,0,1,  1,0,1,1, "t1_beat1");
    add(0, 1,0,0,0,1,  1,0,1,1, "t1_beat2");
    add(0, 1,1,0,0,1,  1,0,1,1, "t1_beat3_last");
    add(0, 0,0,0,0,1,  1,0,1,0, "t1_regrant_drop");
    add(0, 0,0,0,0,1,  0,0,1,0, "t1_idle_hold_sel");
    // The pointer now favours "zero" after the release of "one".
    add(0, 1,1,1,1,1,  0,0,1,0, "t1_tie_idle");
    add(0, 0,0,1,1,1,  0,1,0,1, "t1_tie_to_zero");
    // 2: both requesters, last on every beat -> strict alternation
    add(1, 1,1,1,1,1,  0,0,0,0, "t2_idle");
    add(0, 1,1,1,1,1,  1,0,1,1, "t2_one");
    add(0, 1,1,1,1,1,  0,1,0,1, "t2_zero");
    add(0, 1,1,1,1,1,  1,0,1,1, "t2_one");
    add(0, 1,1,1,1,1,  0,1,0,1, "t2_zero");
    // 3: "one" alone, never last -> forced release after 8, fresh re-grant
    add(1, 1,0,0,0,1,  0,0,0,0, "t3_idle");
    add(0, 1,0,0,0,1,  1,0,1,1, "t3_burst1", 8);
    add(0, 1,0,1,0,1,  1,0,1,1, "t3_burst2", 8);
    add(0, 1,0,1,0,1,  0,1,0,1, "t3_handover");
    // 4: "zero" stalled for 5 cycles, count frozen, then a full 8-beat burst
    add(1, 0,0,1,0,1,  0,0,0,0, "t4_idle");
    add(0, 0,0,1,0,0,  0,1,0,1, "t4_stall", 5);
    add(0, 1,0,1,0,1,  0,1,0,1, "t4_beats", 8);
    add(0, 1,0,1,0,1,  1,0,1,1, "t4_handover");
    // 5: "zero" drops its request mid-burst while "one" waits
    add(1, 0,0,1,0,1,  0,0,0,0, "t5_idle");
    add(0, 1,0,1,0,1,  0,1,0,1, "t5_beat1");
    add(0, 1,0,1,0,1,  0,1,0,1, "t5_beat2");
    add(0, 1,0,0,0,1,  0,1,0,0, "t5_drop");
    add(0, 1,1,0,0,1,  1,0,1,1, "t5_one");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rb) pulse_reset();
      req_one   = vecs[i].r1;
      last_one  = vecs[i].l1;
      req_zero  = vecs[i].r0;
      last_zero = vecs[i].l0;
      out_ready = vecs[i].rdy;
      #1;
      $display("[TB] vec %0d %s: g1=%b g0=%b sel=%b val=%b", i, vecs[i].tag,
               grant_one, grant_zero, select, out_valid);
      check_outputs($sformatf("vec%0d_%s", i, vecs[i].tag),
                    vecs[i].g1, vecs[i].g0, vecs[i].sel, vecs[i].val);
    end

    // 6: asynchronous reset in the middle of a burst
    @(negedge clk);
    pulse_reset();
    req_one = 1'b1; last_one = 1'b0;
    req_zero = 1'b1; last_zero = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("[TB] t6 mid-burst: g1=%b g0=%b sel=%b val=%b",
             grant_one, grant_zero, select, out_valid);
    check_outputs("t6_pre_reset", 1, 0, 1, 1);
    #1;
    rst = 1'b1;
    #1;
    $display("[TB] t6 reset asserted: g1=%b g0=%b sel=%b val=%b",
             grant_one, grant_zero, select, out_valid);
    check_outputs("t6_async_reset", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_outputs("t6_reset_held", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] t6 after reset: g1=%b g0=%b sel=%b val=%b",
             grant_one, grant_zero, select, out_valid);
    check_outputs("t6_first_tie_one", 1, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
